// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit that feeds the CPU HI/LO registers.
// Multiplies by shift-add and divides by restoring division. Both work on
// operand magnitudes, and the signs are applied in a single FIX cycle at the end.
//
// Handshake: a start request (start_mult or start_div) is taken only while
// the unit is in IDLE, and start_mult wins when both are high. busy is high
// while iterations are running (or while a divide-by-zero is being
// reported). done pulses for one cycle once the result is available on hi/lo.
// A new start may be presented in the same cycle as done.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mag_op;    // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;       // mult: {upper, multiplier}; div: {remainder, dividend/quotient}
    logic               is_mult;
    logic               neg_res;   // product or quotient must be negated
    logic               neg_rem;   // remainder must be negated (negative dividend)

    logic               accept_mult;
    logic               accept_div;
    logic               last_iter;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] mult_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign state_dbg = state;

    // busy drops once the iterations finish. FIX is the write-back cycle, so
    // busy is already low there and done follows it.
    assign busy = (state == MULT) || (state == DIV) || (state == DONE);

    assign accept_mult = (state == IDLE) && start_mult;
    assign accept_div  = (state == IDLE) && !start_mult && start_div;
    assign last_iter   = (count == CNT_W'(1));

    // Operand magnitudes, one iteration step of each engine, and sign correction
    always_comb begin
        mag_a_in = op_a;
        mag_b_in = op_b;
        if (signed_op && op_a[WIDTH-1]) mag_a_in = -op_a;
        if (signed_op && op_b[WIDTH-1]) mag_b_in = -op_b;

        // shift-add: add the multiplicand when the current multiplier bit is set
        mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_op} : {(WIDTH+1){1'b0}});
        mult_next = {mult_sum, acc[WIDTH-1:1]};

        // restoring division: trial subtract, keep the result only if non-negative
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_op};
        if (div_diff[WIDTH])
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fixed = neg_res ? -acc : acc;
        quot_fixed = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_mult)
                    state_nx = MULT;
                else if (accept_div)
                    state_nx = (op_b == '0) ? DONE : DIV;
            end
            MULT:    if (last_iter) state_nx = FIX;
            DIV:     if (last_iter) state_nx = FIX;
            FIX:     state_nx = IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and HI/LO write-back
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            mag_op   <= '0;
            acc      <= '0;
            is_mult  <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= (state == FIX) || (state == DONE);
            div_zero <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept_mult || accept_div) begin
                        count   <= CNT_W'(WIDTH);
                        mag_op  <= mag_b_in;
                        acc     <= {{WIDTH{1'b0}}, mag_a_in};
                        is_mult <= accept_mult;
                        neg_res <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_rem <= signed_op && op_a[WIDTH-1];
                    end
                end
                MULT: begin
                    acc   <= mult_next;
                    count <= count - CNT_W'(1);
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    if (is_mult) begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end else begin
                        hi <= rem_fixed;
                        lo <= quot_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
